// File: rtl/rotate_sequencer.sv
// rotate_sequencer: command-driven lap/pause controller for the rotate datapath.
// Optional macro ROTATE_SEQ_PINGPONG_EN: alternate direction on each lap boundary.
module rotate_sequencer #(
    parameter int LAP_W         = 4,
    parameter int STEPS_PER_LAP = 8,
    parameter int PAUSE_CYCLES  = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [LAP_W-1:0] cmd_laps,
    input  logic             abort,
    input  logic             step_strobe,
    output logic             enable,
    output logic             clockwise,
    output logic             busy,
    output logic             done,
    output logic [LAP_W-1:0] laps_left
);

    localparam int STEP_W  = (STEPS_PER_LAP > 1) ? $clog2(STEPS_PER_LAP) : 1;
    localparam int PAUSE_W = $clog2(PAUSE_CYCLES + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;

    localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(STEPS_PER_LAP - 1);
    localparam logic [STEP_W-1:0]  STEP_ONE   = STEP_W'(1);
    localparam logic [PAUSE_W-1:0] PAUSE_LAST = PAUSE_W'(PAUSE_CYCLES - 1);
    localparam logic [PAUSE_W-1:0] PAUSE_ONE  = PAUSE_W'(1);
    localparam logic [LAP_W-1:0]   LAP_ONE    = LAP_W'(1);

    logic [1:0]         state_q;
    logic [1:0]         state_d;
    logic [STEP_W-1:0]  step_q;
    logic [STEP_W-1:0]  step_d;
    logic [PAUSE_W-1:0] pause_q;
    logic [PAUSE_W-1:0] pause_d;
    logic [LAP_W-1:0]   laps_d;
    logic               en_d;
    logic               cw_d;
    logic               busy_d;
    logic               done_d;
    logic               accept;
    logic               lap_end;
    logic               cw_flip;

    // Ready only when idle and not being cancelled; combinational by design.
    assign cmd_ready = reset_n & (state_q == S_IDLE) & ~abort;
    assign accept    = cmd_valid & cmd_ready;
    assign lap_end   = step_strobe & (step_q == STEP_LAST);

    // Direction applied at a lap boundary that does not finish the command.
`ifdef ROTATE_SEQ_PINGPONG_EN
    assign cw_flip = ~clockwise;
`else
    assign cw_flip = clockwise;
`endif

    // Next-state and next-output logic for the IDLE/RUN/PAUSE sequencer.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        pause_d = pause_q;
        laps_d  = laps_left;
        en_d    = enable;
        cw_d    = clockwise;
        busy_d  = busy;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (cmd_laps == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        laps_d  = cmd_laps;
                        cw_d    = cmd_dir;
                        step_d  = '0;
                        pause_d = '0;
                        en_d    = 1'b1;
                        busy_d  = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    step_d  = '0;
                    pause_d = '0;
                    laps_d  = '0;
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                end else if (lap_end) begin
                    step_d = '0;
                    if (laps_left != '0) begin
                        laps_d = laps_left - LAP_ONE;
                    end
                    if (laps_left == LAP_ONE) begin
                        state_d = S_PAUSE;
                        pause_d = '0;
                        en_d    = 1'b0;
                    end else begin
                        cw_d = cw_flip;
                    end
                end else if (step_strobe) begin
                    step_d = step_q + STEP_ONE;
                end
            end
            S_PAUSE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    step_d  = '0;
                    pause_d = '0;
                    laps_d  = '0;
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                end else if (pause_q == PAUSE_LAST) begin
                    state_d = S_IDLE;
                    pause_d = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    pause_d = pause_q + PAUSE_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                step_d  = '0;
                pause_d = '0;
                laps_d  = '0;
                en_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, counters and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            step_q    <= '0;
            pause_q   <= '0;
            laps_left <= '0;
            enable    <= 1'b0;
            clockwise <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            pause_q   <= pause_d;
            laps_left <= laps_d;
            enable    <= en_d;
            clockwise <= cw_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_rotate_sequencer.sv
// tb_rotate_sequencer: directed plus random stimulus for rotate_sequencer.
// Reference model tracks total strobes and pause cycles remaining.
module tb_rotate_sequencer;

    localparam int LAP_W = 4;
    localparam int SPL   = 8;
    localparam int PC    = 16;
`ifdef ROTATE_SEQ_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_dir = 1'b0;
    logic [LAP_W-1:0] cmd_laps = '0;
    logic             abort = 1'b0;
    logic             step_strobe = 1'b0;
    logic             cmd_ready;
    logic             enable;
    logic             clockwise;
    logic             busy;
    logic             done;
    logic [LAP_W-1:0] laps_left;

    int passed = 0;
    int total  = 0;

    int m_strobes = 0;
    int m_pause   = 0;
    bit m_cw      = 1'b1;
    bit m_done    = 1'b0;

    rotate_sequencer #(
        .LAP_W(LAP_W),
        .STEPS_PER_LAP(SPL),
        .PAUSE_CYCLES(PC)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir),
        .cmd_laps(cmd_laps),
        .abort(abort),
        .step_strobe(step_strobe),
        .enable(enable),
        .clockwise(clockwise),
        .busy(busy),
        .done(done),
        .laps_left(laps_left)
    );

    always #5 clk = ~clk;

    function automatic bit m_idle();
        return (m_strobes == 0) && (m_pause == 0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic m_reset();
        m_strobes = 0;
        m_pause   = 0;
        m_cw      = 1'b1;
        m_done    = 1'b0;
    endtask

    // Model: a command is laps*SPL strobes of work followed by PC idle cycles.
    task automatic m_edge();
        m_done = 1'b0;
        if (!reset_n) begin
            m_reset();
        end else if (!m_idle() && abort) begin
            m_strobes = 0;
            m_pause   = 0;
        end else if (m_idle()) begin
            if (cmd_valid && !abort) begin
                if (cmd_laps == '0) begin
                    m_done = 1'b1;
                end else begin
                    m_strobes = int'(cmd_laps) * SPL;
                    m_cw      = cmd_dir;
                end
            end
        end else if (m_strobes > 0) begin
            if (step_strobe) begin
                m_strobes--;
                if (m_strobes == 0) m_pause = PC;
                else if ((m_strobes % SPL) == 0 && PP) m_cw = ~m_cw;
            end
        end else begin
            m_pause--;
            if (m_pause == 0) m_done = 1'b1;
        end
    endtask

    task automatic chk_out();
        chk("enable", enable, m_strobes > 0);
        chk("busy", busy, !m_idle());
        chk("done", done, m_done);
        chk("laps_left", laps_left, (m_strobes + SPL - 1) / SPL);
        chk("clockwise", clockwise, m_cw);
    endtask

    task automatic tick();
        #1;
        chk("cmd_ready", cmd_ready, reset_n && m_idle() && !abort);
        @(posedge clk);
        m_edge();
        #1;
        chk_out();
    endtask

    task automatic run_until_idle(input int budget);
        int c;
        c = 0;
        while ((busy || !m_idle()) && c < budget) begin
            step_strobe = 1'($urandom);
            tick();
            c++;
        end
        step_strobe = 1'b0;
        chk("idle_timeout", busy, 1'b0);
    endtask

    initial begin
        int  n_str;
        int  n_pause;
        int  n_done;
        int  n_rdy;
        bit  pre_en;
        bit  pre_cw;
        bit  s;

        // Reset with a command pending
        reset_n   = 1'b0;
        cmd_valid = 1'b1;
        cmd_laps  = 4'd2;
        repeat (3) tick();
        chk("rst_ready", cmd_ready, 1'b0);
        reset_n   = 1'b1;
        cmd_valid = 1'b0;
        tick();
        chk("rel_ready", cmd_ready, 1'b1);

        // Normal run: 2 laps clockwise, strobe every 4th cycle
        cmd_valid = 1'b1;
        cmd_dir   = 1'b1;
        cmd_laps  = 4'd2;
        tick();
        cmd_valid = 1'b0;
        chk("run_en_after_accept", enable, 1'b1);
        n_str   = 0;
        n_pause = 0;
        n_done  = 0;
        for (int c = 0; c < 400 && n_done == 0; c++) begin
            step_strobe = (c % 4 == 3);
            s      = step_strobe;
            pre_en = enable;
            pre_cw = clockwise;
            tick();
            if (s && pre_en) begin
                chk("cw_per_strobe", pre_cw, !PP || n_str < 8);
                n_str++;
                if (n_str == 8) chk("laps_after8", laps_left, 1);
                if (n_str == 16) chk("laps_after16", laps_left, 0);
            end
            if (busy && !enable) n_pause++;
            if (done) begin
                n_done++;
                chk("ready_at_done", cmd_ready, 1'b1);
            end
        end
        step_strobe = 1'b0;
        chk("run_strobes", n_str, 16);
        chk("run_pause_len", n_pause, PC);
        chk("run_done_cnt", n_done, 1);
        tick();
        chk("done_one_cycle", done, 1'b0);

        // Zero laps
        cmd_valid = 1'b1;
        cmd_laps  = 4'd0;
        tick();
        cmd_valid = 1'b0;
        chk("zero_done", done, 1'b1);
        chk("zero_en", enable, 1'b0);
        chk("zero_busy", busy, 1'b0);
        tick();
        chk("zero_done_clr", done, 1'b0);

        // Abort coincident with the 6th strobe
        cmd_valid = 1'b1;
        cmd_dir   = 1'b0;
        cmd_laps  = 4'd3;
        tick();
        cmd_valid = 1'b0;
        n_str = 0;
        for (int c = 0; c < 200; c++) begin
            step_strobe = (c % 4 == 3);
            if (step_strobe && n_str == 5) abort = 1'b1;
            s = step_strobe;
            tick();
            if (s) n_str++;
            if (abort) break;
        end
        abort       = 1'b0;
        step_strobe = 1'b0;
        chk("abort_en", enable, 1'b0);
        chk("abort_laps", laps_left, 0);
        chk("abort_done", done, 1'b0);
        chk("abort_busy", busy, 1'b0);
        cmd_valid = 1'b1;
        cmd_dir   = 1'b1;
        cmd_laps  = 4'd1;
        tick();
        cmd_valid = 1'b0;
        chk("abort_reaccept", busy, 1'b1);
        run_until_idle(400);
        tick();

        // Backpressure: second command held during RUN/PAUSE
        cmd_valid = 1'b1;
        cmd_dir   = 1'b1;
        cmd_laps  = 4'd1;
        tick();
        cmd_dir     = 1'b0;
        cmd_laps    = 4'd1;
        step_strobe = 1'b1;
        n_rdy = 0;
        n_done = 0;
        for (int c = 0; c < 100 && n_done == 0; c++) begin
            tick();
            if (busy && cmd_ready) n_rdy++;
            if (done) n_done++;
        end
        chk("bp_ready_low", n_rdy, 0);
        chk("bp_done_seen", n_done, 1);
        chk("bp_ready_at_done", cmd_ready, 1'b1);
        step_strobe = 1'b0;
        tick();
        cmd_valid = 1'b0;
        chk("bp_second_en", enable, 1'b1);
        chk("bp_second_cw", clockwise, 1'b0);
        run_until_idle(400);

        // Reset asserted mid-command
        cmd_valid   = 1'b1;
        cmd_dir     = 1'b0;
        cmd_laps    = 4'd3;
        tick();
        step_strobe = 1'b1;
        repeat (5) tick();
        #2;
        reset_n = 1'b0;
        #1;
        m_reset();
        chk_out();
        chk("midrst_ready", cmd_ready, 1'b0);
        repeat (2) tick();
        reset_n     = 1'b1;
        cmd_valid   = 1'b0;
        step_strobe = 1'b0;
        tick();
        chk("midrst_rel_ready", cmd_ready, 1'b1);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            cmd_valid   = ($urandom_range(0, 3) == 0);
            cmd_dir     = 1'($urandom);
            cmd_laps    = LAP_W'($urandom_range(0, 3));
            step_strobe = 1'($urandom);
            abort       = ($urandom_range(0, 79) == 0);
            tick();
        end
        abort     = 1'b0;
        cmd_valid = 1'b0;
        run_until_idle(600);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
